// File: rtl/md_ctrl.sv
// Execute-stage multiply/divide controller: owns HI/LO, runs fixed-latency busy
// periods for mult/div, and raises the D-stage stall while the unit is occupied.
module md_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_mdop,
    input  logic [WIDTH-1:0] e_rs,
    input  logic [WIDTH-1:0] e_rt,
    input  logic             d_mden,
    output logic             start,
    output logic             busy,
    output logic             stall_md,
    output logic [WIDTH-1:0] md_rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic is_mul, is_div, div_ovf;
    logic [2*WIDTH-1:0] rs_sx, rt_sx, rs_zx, rt_zx, prod;
    logic [WIDTH-1:0]   div_u, div_s, q_u, r_u;
    logic signed [WIDTH-1:0] q_s, r_s;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign is_mul = (e_mdop == OP_MULT) || (e_mdop == OP_MULTU);
    assign is_div = (e_mdop == OP_DIV)  || (e_mdop == OP_DIVU);

    assign start    = e_valid && (is_mul || is_div) && (state_q == ST_IDLE);
    assign busy     = (state_q == ST_BUSY);
    assign stall_md = d_mden && (busy || start);
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        md_rdata = '0;
        if (e_mdop == OP_MFHI)      md_rdata = hi_q;
        else if (e_mdop == OP_MFLO) md_rdata = lo_q;
    end

    assign rs_sx = {{WIDTH{e_rs[WIDTH-1]}}, e_rs};
    assign rt_sx = {{WIDTH{e_rt[WIDTH-1]}}, e_rt};
    assign rs_zx = {{WIDTH{1'b0}}, e_rs};
    assign rt_zx = {{WIDTH{1'b0}}, e_rt};
    assign prod  = (e_mdop == OP_MULT) ? rs_sx * rt_sx : rs_zx * rt_zx;

    // Divisors are forced to 1 for x/0 (result discarded anyway) and for
    // MIN/-1, where dividing by 1 yields exactly the wrapped quotient and zero remainder.
    assign div_ovf = (e_rs == {1'b1, {(WIDTH-1){1'b0}}}) && (e_rt == {WIDTH{1'b1}});
    assign div_u   = (e_rt == '0) ? WIDTH'(1) : e_rt;
    assign div_s   = ((e_rt == '0) || div_ovf) ? WIDTH'(1) : e_rt;
    assign q_u     = e_rs / div_u;
    assign r_u     = e_rs % div_u;
    assign q_s     = $signed(e_rs) / $signed(div_s);
    assign r_s     = $signed(e_rs) % $signed(div_s);

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (e_mdop == OP_DIV) begin
            res_hi = r_s;
            res_lo = q_s;
        end else if (e_mdop == OP_DIVU) begin
            res_hi = r_u;
            res_lo = q_u;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                pend_hi_d = res_hi;
                pend_lo_d = res_lo;
                pend_wr_d = !(is_div && (e_rt == '0));
                cnt_d     = is_mul ? CW'(MULT_LAT) : CW'(DIV_LAT);
                state_d   = ST_BUSY;
            end else if (e_valid && (e_mdop == OP_MTHI)) begin
                hi_d = e_rs;
            end else if (e_valid && (e_mdop == OP_MTLO)) begin
                lo_d = e_rs;
            end
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = ST_IDLE;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end
endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: hand-computed vectors checked one cycle at a time
// with immediate assertions, sampled 1ns after each rising edge.
module tb_md_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_mdop;
    logic [31:0] e_rs, e_rt;
    logic        d_mden;
    logic        start, busy, stall_md;
    logic [31:0] md_rdata, hi, lo;

    int n_vec = 0;
    int n_err = 0;

    md_ctrl #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_mdop(e_mdop),
        .e_rs(e_rs), .e_rt(e_rt), .d_mden(d_mden), .start(start),
        .busy(busy), .stall_md(stall_md), .md_rdata(md_rdata), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; an MD op presented to a busy unit is a protocol violation.
    task automatic step();
        if (reset && busy && e_valid && (e_mdop >= 4'd1) && (e_mdop <= 4'd8)) begin
            n_err++;
            $error("FAIL protocol op=%0d observed=busy expected=idle", e_mdop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        e_valid = 1'b0;
        e_mdop  = 4'd0;
        e_rs    = 32'd0;
        e_rt    = 32'd0;
    endtask

    // Present an op for one cycle (cycle T), check start, then clear E.
    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic exp_start);
        e_valid = 1'b1;
        e_mdop  = op;
        e_rs    = rs;
        e_rt    = rt;
        #1;
        chk("start", {31'd0, start}, {31'd0, exp_start});
        step();
        idle_inputs();
    endtask

    // After issue(): checks busy for cycles T+1..T+lat, then idle and results at T+lat+1.
    task automatic run_busy(input string tag, input int lat, input logic [31:0] old_hi,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        for (int i = 1; i <= lat; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (i == lat) chk({tag, "_hi_hold"}, hi, old_hi);
            step();
        end
        chk({tag, "_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        reset  = 1'b0;
        d_mden = 1'b0;
        idle_inputs();
        step();
        step();
        reset = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_stall", {31'd0, stall_md}, 32'd0);

        // mult -2 * 3 = -6
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        run_busy("mult", 5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // divu 100/7, then div -7/2
        issue(4'd4, 32'd100, 32'd7, 1'b1);
        run_busy("divu", 10, 32'hFFFF_FFFF, 32'd2, 32'd14);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_busy("div", 10, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // mthi/mtlo and mfhi/mflo
        issue(4'd7, 32'h1234, 32'd0, 1'b0);
        issue(4'd8, 32'h5678, 32'd0, 1'b0);
        chk("mthi", hi, 32'h1234);
        chk("mtlo", lo, 32'h5678);
        e_mdop = 4'd5; #1;
        chk("mfhi", md_rdata, 32'h1234);
        e_mdop = 4'd6; #1;
        chk("mflo", md_rdata, 32'h5678);
        e_mdop = 4'd0; #1;
        chk("mf_none", md_rdata, 32'd0);
        e_mdop = 4'd7; e_rs = 32'hFFFF; e_valid = 1'b0;
        step();
        idle_inputs();
        chk("mthi_invalid", hi, 32'h1234);

        // multu with D-stage MD op held: stall T..T+5
        d_mden = 1'b1;
        #1;
        chk("stall_idle", {31'd0, stall_md}, 32'd0);
        e_valid = 1'b1; e_mdop = 4'd2; e_rs = 32'hFFFF_FFFF; e_rt = 32'd2;
        #1;
        chk("stall_T", {31'd0, stall_md}, 32'd1);
        step();
        idle_inputs();
        for (int i = 1; i <= 5; i++) begin
            chk("stall_busy", {31'd0, stall_md}, 32'd1);
            step();
        end
        chk("stall_drop", {31'd0, stall_md}, 32'd0);
        chk("multu_hi", hi, 32'd1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        d_mden = 1'b0;

        // div by zero leaves HI/LO untouched after a full busy period
        issue(4'd7, 32'hAA, 32'd0, 1'b0);
        issue(4'd8, 32'hBB, 32'd0, 1'b0);
        issue(4'd3, 32'd5, 32'd0, 1'b1);
        chk("stall_nomden", {31'd0, stall_md}, 32'd0);
        run_busy("div0", 10, 32'hAA, 32'hAA, 32'hBB);

        // most-negative / -1
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_busy("divovf", 10, 32'hAA, 32'd0, 32'h8000_0000);

        // reset in the middle of a mult
        issue(4'd7, 32'h77, 32'd0, 1'b0);
        issue(4'd1, 32'd3, 32'd4, 1'b1);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rstmid_after_lo", lo, 32'd0);
        end
        chk("rstmid_after_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Execute-stage controller for the pipeline's multiply/divide unit.
- Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from E and owns the HI/LO registers.
- Sequences multi-cycle busy periods.
- Generates the stall request D needs when an MD-class instruction must wait for the unit.

Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_LAT, 5, busy cycles for mult/multu (≥1)
- DIV_LAT, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
- e_valid  in  1  E-stage instruction valid, not flushed
- e_mdop  in  4  MD op in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others = none
- e_rs  in  WIDTH  forwarded rs value in E
- e_rt  in  WIDTH  forwarded rt value in E
- d_mden  in  1  D-stage instruction is any MD-class op
- start  out  1  combinational; a mult/div is accepted this cycle
- busy  out  1  registered; unit computing
- stall_md  out  1  combinational stall request to D
- md_rdata  out  WIDTH  combinational mfhi/mflo read data
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset==0 at posedge):
  - state←IDLE, busy=0, hi=lo=0, counter=0, pending results=0.
  - Aborts any in-flight operation; its result is discarded.
- States:
  - IDLE, BUSY.
  - A 1-bit state plus a down-counter wide enough for max(MULT_LAT, DIV_LAT).
- start:
  - start = e_valid & (e_mdop∈{1..4}) & state==IDLE.
- Accept at edge T (start=1):
  - Latch the result into pending regs; the arithmetic may be computed combinationally from e_rs/e_rt at T.
  - counter←MULT_LAT or DIV_LAT; state←BUSY.
- busy is 1 during cycles T+1 … T+LAT.
- At the edge ending cycle T+LAT (counter==1): hi/lo←pending, state←IDLE.
- New hi/lo are visible from cycle T+LAT+1.
- Arithmetic:
  - mult: {hi,lo}=signed 2W product.
  - multu: unsigned 2W product.
  - div: lo=signed quotient truncated toward zero; hi=remainder with the sign of the dividend (rs).
  - divu: unsigned quotient/remainder.
  - Divisor rt==0: hi/lo left unchanged at completion; busy period still runs its full DIV_LAT.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo:
  - Accepted only when e_valid & state==IDLE.
  - hi (or lo)←e_rs at that edge.
  - In BUSY they are ignored; the stall prevents them from arriving.
- mfhi/mflo: md_rdata = hi (op 5) or lo (op 6), else 0. This is purely combinational.
- Ops arriving in E while BUSY are ignored (no state change). A bench assertion flags this as a protocol violation.
- Stall: stall_md = d_mden & (busy | start).
  - The D-stage MD instruction is held while the unit computes or has just accepted.
  - stall_md drops in cycle T+LAT+1.
- Simultaneous completion and new E op at the edge where counter==1: the new op is ignored (state is still BUSY); it cannot occur legally because of the stall.
- Reset asserted mid-BUSY: the next cycle is IDLE with hi=lo=0 and busy=0.
- e_valid=0 suppresses every action, including mthi/mtlo.

Test Plan:
1. Reset, then mult rs=0xFFFFFFFE (−2), rt=3 → start=1 at T; busy=1 for T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. divu rs=100, rt=7 then div rs=−7 (0xFFFFFFF9), rt=2 → first: busy 10 cycles, lo=14, hi=2; second: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. mthi rs=0x1234, mtlo rs=0x5678 in IDLE → next cycle hi=0x1234, lo=0x5678; mfhi gives md_rdata=0x1234, mflo gives 0x5678.
4. During busy from multu, hold d_mden=1 → stall_md=1 from T through T+5 inclusive; 0 at T+6; also stall_md=0 when d_mden=0.
5. div rt=0 with hi=0xAA, lo=0xBB → busy 10 cycles; hi/lo unchanged. Separately, div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
6. Start mult, assert reset=0 at T+2 → from T+3: busy=0, hi=lo=0; the later completion edge changes nothing.
